// File: rtl/cc_alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM states, ALU selection codes,
// condition codes and the bit positions of the {N,Z,V,C} status register.
package cc_alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seqState_t;

  localparam logic [3:0] ALU_OP_BUSA = 4'b0000;
  localparam logic [3:0] ALU_OP_OR   = 4'b0001;
  localparam logic [3:0] ALU_OP_AND  = 4'b0010;
  localparam logic [3:0] ALU_OP_NOT  = 4'b0011;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OP_ADD  = 4'b1000;
  localparam logic [3:0] ALU_OP_SUB  = 4'b1001;
  localparam logic [3:0] ALU_OP_INC  = 4'b1010;
  localparam logic [3:0] ALU_OP_DEC  = 4'b1011;
  localparam logic [3:0] ALU_OP_NOP  = 4'b1111;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_N      = 3'b011;
  localparam logic [2:0] COND_NN     = 3'b100;
  localparam logic [2:0] COND_C      = 3'b101;
  localparam logic [2:0] COND_V      = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // The ALU reports its flags active-low; the status register is active-high.
  function automatic logic [3:0] packFlags(input logic negativeLow,
                                           input logic zeroLow,
                                           input logic overflowLow,
                                           input logic carryLow);
    logic [3:0] flags;
    flags = 4'b0000;
    flags[FLAG_N] = ~negativeLow;
    flags[FLAG_Z] = ~zeroLow;
    flags[FLAG_V] = ~overflowLow;
    flags[FLAG_C] = ~carryLow;
    return flags;
  endfunction

endpackage

// File: rtl/cc_alu_cond_eval.sv
// Combinational branch-condition evaluator over an active-high {N,Z,V,C}
// status word.
module cc_alu_cond_eval
  import cc_alu_seq_pkg::*;
#(
  parameter int DATAWIDTH_COND = 3
) (
  input  logic [3:0]                flags,
  input  logic [DATAWIDTH_COND-1:0] cond,
  output logic                      condTrue
);

  // Select the flag test named by the condition code.
  always_comb begin
    condTrue = 1'b0;
    case (cond)
      COND_ALWAYS: condTrue = 1'b1;
      COND_Z:      condTrue = flags[FLAG_Z];
      COND_NZ:     condTrue = ~flags[FLAG_Z];
      COND_N:      condTrue = flags[FLAG_N];
      COND_NN:     condTrue = ~flags[FLAG_N];
      COND_C:      condTrue = flags[FLAG_C];
      COND_V:      condTrue = flags[FLAG_V];
      COND_NEVER:  condTrue = 1'b0;
      default:     condTrue = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_alu_sequencer.sv
// ALU sequencer: accepts one request, drives the ALU for a single EXEC cycle,
// captures result/flags/condition and holds a response until it is taken.
// Optional feature macro CC_ALUSEQ_CHAIN_EN adds CC_ALUSEQ_reqChain_In, which
// feeds the last captured result back as operand A.
module cc_alu_sequencer
  import cc_alu_seq_pkg::*;
#(
  parameter int DATAWIDTH_BUS           = 8,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_COND          = 3
) (
  input  logic                               CC_ALUSEQ_CLOCK_50,
  input  logic                               CC_ALUSEQ_RESET_InHigh,
  input  logic                               CC_ALUSEQ_reqValid_In,
  output logic                               CC_ALUSEQ_reqReady_Out,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_reqOp_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_reqDataA_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_reqDataB_InBUS,
  input  logic [DATAWIDTH_COND-1:0]          CC_ALUSEQ_reqCond_InBUS,
`ifdef CC_ALUSEQ_CHAIN_EN
  input  logic                               CC_ALUSEQ_reqChain_In,
`endif
  output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluDataA_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluDataB_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_aluSelection_OutBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluData_InBUS,
  input  logic                               CC_ALUSEQ_aluOverflow_InLow,
  input  logic                               CC_ALUSEQ_aluCarry_InLow,
  input  logic                               CC_ALUSEQ_aluNegative_InLow,
  input  logic                               CC_ALUSEQ_aluZero_InLow,
  output logic                               CC_ALUSEQ_rspValid_Out,
  input  logic                               CC_ALUSEQ_rspReady_In,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_rspData_OutBUS,
  output logic [3:0]                         CC_ALUSEQ_rspFlags_OutBUS,
  output logic                               CC_ALUSEQ_rspCondTrue_Out
);

  seqState_t                        state;
  seqState_t                        nextState;
  logic [DATAWIDTH_ALU_SELECTION-1:0] opReg;
  logic [DATAWIDTH_BUS-1:0]           dataAReg;
  logic [DATAWIDTH_BUS-1:0]           dataBReg;
  logic [DATAWIDTH_COND-1:0]          condReg;
  logic [DATAWIDTH_BUS-1:0]           rspDataReg;
  logic [3:0]                         rspFlagsReg;
  logic                               rspCondReg;
  logic [DATAWIDTH_BUS-1:0]           nextOperandA;
  logic [3:0]                         capturedFlags;
  logic                               capturedCond;
  logic                               acceptReq;

  assign acceptReq = (state == IDLE) && CC_ALUSEQ_reqValid_In;

`ifdef CC_ALUSEQ_CHAIN_EN
  assign nextOperandA = CC_ALUSEQ_reqChain_In ? rspDataReg : CC_ALUSEQ_reqDataA_InBUS;
`else
  assign nextOperandA = CC_ALUSEQ_reqDataA_InBUS;
`endif

  assign capturedFlags = packFlags(CC_ALUSEQ_aluNegative_InLow, CC_ALUSEQ_aluZero_InLow,
                                   CC_ALUSEQ_aluOverflow_InLow, CC_ALUSEQ_aluCarry_InLow);

  cc_alu_cond_eval #(
    .DATAWIDTH_COND(DATAWIDTH_COND)
  ) condEval (
    .flags   (capturedFlags),
    .cond    (condReg),
    .condTrue(capturedCond)
  );

  // State register; reset drops any in-flight operation.
  always_ff @(posedge CC_ALUSEQ_CLOCK_50 or posedge CC_ALUSEQ_RESET_InHigh) begin
    if (CC_ALUSEQ_RESET_InHigh) state <= IDLE;
    else                        state <= nextState;
  end

  // Next-state and handshake/ALU bus decode; the ALU sees a no-op outside EXEC.
  always_comb begin
    nextState                     = state;
    CC_ALUSEQ_reqReady_Out        = 1'b0;
    CC_ALUSEQ_rspValid_Out        = 1'b0;
    CC_ALUSEQ_aluDataA_OutBUS     = '0;
    CC_ALUSEQ_aluDataB_OutBUS     = '0;
    CC_ALUSEQ_aluSelection_OutBUS = ALU_OP_NOP;
    case (state)
      IDLE: begin
        CC_ALUSEQ_reqReady_Out = 1'b1;
        if (CC_ALUSEQ_reqValid_In) nextState = EXEC;
      end
      EXEC: begin
        CC_ALUSEQ_aluDataA_OutBUS     = dataAReg;
        CC_ALUSEQ_aluDataB_OutBUS     = dataBReg;
        CC_ALUSEQ_aluSelection_OutBUS = opReg;
        nextState                     = RESP;
      end
      RESP: begin
        CC_ALUSEQ_rspValid_Out = 1'b1;
        if (CC_ALUSEQ_rspReady_In) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Latch the request on acceptance and the full ALU result at the end of EXEC.
  always_ff @(posedge CC_ALUSEQ_CLOCK_50 or posedge CC_ALUSEQ_RESET_InHigh) begin
    if (CC_ALUSEQ_RESET_InHigh) begin
      opReg       <= '0;
      dataAReg    <= '0;
      dataBReg    <= '0;
      condReg     <= '0;
      rspDataReg  <= '0;
      rspFlagsReg <= 4'b0000;
      rspCondReg  <= 1'b0;
    end else begin
      if (acceptReq) begin
        opReg    <= CC_ALUSEQ_reqOp_InBUS;
        dataAReg <= nextOperandA;
        dataBReg <= CC_ALUSEQ_reqDataB_InBUS;
        condReg  <= CC_ALUSEQ_reqCond_InBUS;
      end
      if (state == EXEC) begin
        rspDataReg  <= CC_ALUSEQ_aluData_InBUS;
        rspFlagsReg <= capturedFlags;
        rspCondReg  <= capturedCond;
      end
    end
  end

  assign CC_ALUSEQ_rspData_OutBUS  = rspDataReg;
  assign CC_ALUSEQ_rspFlags_OutBUS = rspFlagsReg;
  assign CC_ALUSEQ_rspCondTrue_Out = rspCondReg;

endmodule

// File: tb/tb_cc_alu_sequencer.sv
// Directed testbench for cc_alu_sequencer with a small behavioural ALU attached.
module tb_cc_alu_sequencer;
  import cc_alu_seq_pkg::*;

  logic       clock;
  logic       reset;
  logic       reqValid;
  logic       reqReady;
  logic [3:0] reqOp;
  logic [7:0] reqDataA;
  logic [7:0] reqDataB;
  logic [2:0] reqCond;
  logic       reqChain;
  logic [7:0] aluDataA;
  logic [7:0] aluDataB;
  logic [3:0] aluSelection;
  logic [7:0] aluData;
  logic       aluOverflowLow;
  logic       aluCarryLow;
  logic       aluNegativeLow;
  logic       aluZeroLow;
  logic       rspValid;
  logic       rspReady;
  logic [7:0] rspData;
  logic [3:0] rspFlags;
  logic       rspCondTrue;

  logic [8:0] aluExt;
  logic       aluV;
  logic       aluC;

  int compared   = 0;
  int mismatched = 0;

  cc_alu_sequencer dut (
    .CC_ALUSEQ_CLOCK_50           (clock),
    .CC_ALUSEQ_RESET_InHigh       (reset),
    .CC_ALUSEQ_reqValid_In        (reqValid),
    .CC_ALUSEQ_reqReady_Out       (reqReady),
    .CC_ALUSEQ_reqOp_InBUS        (reqOp),
    .CC_ALUSEQ_reqDataA_InBUS     (reqDataA),
    .CC_ALUSEQ_reqDataB_InBUS     (reqDataB),
    .CC_ALUSEQ_reqCond_InBUS      (reqCond),
`ifdef CC_ALUSEQ_CHAIN_EN
    .CC_ALUSEQ_reqChain_In        (reqChain),
`endif
    .CC_ALUSEQ_aluDataA_OutBUS    (aluDataA),
    .CC_ALUSEQ_aluDataB_OutBUS    (aluDataB),
    .CC_ALUSEQ_aluSelection_OutBUS(aluSelection),
    .CC_ALUSEQ_aluData_InBUS      (aluData),
    .CC_ALUSEQ_aluOverflow_InLow  (aluOverflowLow),
    .CC_ALUSEQ_aluCarry_InLow     (aluCarryLow),
    .CC_ALUSEQ_aluNegative_InLow  (aluNegativeLow),
    .CC_ALUSEQ_aluZero_InLow      (aluZeroLow),
    .CC_ALUSEQ_rspValid_Out       (rspValid),
    .CC_ALUSEQ_rspReady_In        (rspReady),
    .CC_ALUSEQ_rspData_OutBUS     (rspData),
    .CC_ALUSEQ_rspFlags_OutBUS    (rspFlags),
    .CC_ALUSEQ_rspCondTrue_Out    (rspCondTrue)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural ALU: arithmetic ops set V/C, logic ops clear them; flags active-low.
  always_comb begin
    aluExt = 9'd0;
    aluV   = 1'b0;
    aluC   = 1'b0;
    case (aluSelection)
      ALU_OP_BUSA: aluExt = {1'b0, aluDataA};
      ALU_OP_OR:   aluExt = {1'b0, aluDataA | aluDataB};
      ALU_OP_AND:  aluExt = {1'b0, aluDataA & aluDataB};
      ALU_OP_NOT:  aluExt = {1'b0, ~aluDataA};
      ALU_OP_XOR:  aluExt = {1'b0, aluDataA ^ aluDataB};
      ALU_OP_ADD: begin
        aluExt = {1'b0, aluDataA} + {1'b0, aluDataB};
        aluV   = (aluDataA[7] == aluDataB[7]) && (aluExt[7] != aluDataA[7]);
        aluC   = aluExt[8];
      end
      ALU_OP_SUB: begin
        aluExt = {1'b0, aluDataA} + {1'b0, ~aluDataB} + 9'd1;
        aluV   = (aluDataA[7] != aluDataB[7]) && (aluExt[7] != aluDataA[7]);
        aluC   = aluExt[8];
      end
      ALU_OP_INC: begin
        aluExt = {1'b0, aluDataA} + 9'd1;
        aluV   = ~aluDataA[7] & aluExt[7];
        aluC   = aluExt[8];
      end
      ALU_OP_DEC: begin
        aluExt = {1'b0, aluDataA} + 9'h0FF;
        aluV   = aluDataA[7] & ~aluExt[7];
        aluC   = aluExt[8];
      end
      default: aluExt = 9'd0;
    endcase
    aluData        = aluExt[7:0];
    aluNegativeLow = ~aluExt[7];
    aluZeroLow     = ~(aluExt[7:0] == 8'h00);
    aluOverflowLow = ~aluV;
    aluCarryLow    = ~aluC;
  end

  // Present one request for one edge; returns #1 after the accepting edge (EXEC).
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] cond, input logic chain);
    reqOp    = op;
    reqDataA = a;
    reqDataB = b;
    reqCond  = cond;
    reqChain = chain;
    reqValid = 1'b1;
    @(posedge clock); #1;
    reqValid = 1'b0;
  endtask

  // Accept the pending response for one edge.
  task automatic finishResponse();
    rspReady = 1'b1;
    @(posedge clock); #1;
    rspReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    compared++; if (reqReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_reqReady: got %b expected 1", reqReady); end
    compared++; if (rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rspValid: got %b expected 0", rspValid); end
    compared++; if (aluSelection !== 4'b1111) begin mismatched++; $display("[TB] FAIL reset_aluSel: got %b expected 1111", aluSelection); end
    compared++; if ({aluDataA, aluDataB} !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_aluBus: got %h expected 0000", {aluDataA, aluDataB}); end
    compared++; if ({rspData, rspFlags, rspCondTrue} !== 13'h0) begin mismatched++; $display("[TB] FAIL reset_rsp: got %h expected 0", {rspData, rspFlags, rspCondTrue}); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_add();
    applyStimulus(ALU_OP_ADD, 8'h7F, 8'h01, COND_N, 1'b0);
    compared++; if (rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL add_validEarly: got %b expected 0", rspValid); end
    compared++; if (reqReady !== 1'b0) begin mismatched++; $display("[TB] FAIL add_readyExec: got %b expected 0", reqReady); end
    @(posedge clock); #1;
    compared++; if (rspValid !== 1'b1) begin mismatched++; $display("[TB] FAIL add_valid: got %b expected 1", rspValid); end
    compared++; if (rspData !== 8'h80) begin mismatched++; $display("[TB] FAIL add_data: got %h expected 80", rspData); end
    compared++; if (rspFlags !== 4'b1010) begin mismatched++; $display("[TB] FAIL add_flags: got %b expected 1010", rspFlags); end
    compared++; if (rspCondTrue !== 1'b1) begin mismatched++; $display("[TB] FAIL add_cond: got %b expected 1", rspCondTrue); end
    finishResponse();
    compared++; if ({rspValid, reqReady} !== 2'b01) begin mismatched++; $display("[TB] FAIL add_done: got %b expected 01", {rspValid, reqReady}); end
    compared++; if (rspFlags !== 4'b1010) begin mismatched++; $display("[TB] FAIL add_flagsPersist: got %b expected 1010", rspFlags); end
  endtask

  task automatic test_sub();
    applyStimulus(ALU_OP_SUB, 8'h05, 8'h05, COND_NZ, 1'b0);
    compared++; if (aluSelection !== 4'b1001) begin mismatched++; $display("[TB] FAIL sub_aluSelExec: got %b expected 1001", aluSelection); end
    compared++; if ({aluDataA, aluDataB} !== 16'h0505) begin mismatched++; $display("[TB] FAIL sub_aluBusExec: got %h expected 0505", {aluDataA, aluDataB}); end
    @(posedge clock); #1;
    compared++; if (rspData !== 8'h00) begin mismatched++; $display("[TB] FAIL sub_data: got %h expected 00", rspData); end
    compared++; if ({rspFlags[FLAG_N], rspFlags[FLAG_Z]} !== 2'b01) begin mismatched++; $display("[TB] FAIL sub_flagsNZ: got %b expected 01", {rspFlags[FLAG_N], rspFlags[FLAG_Z]}); end
    compared++; if (rspCondTrue !== 1'b0) begin mismatched++; $display("[TB] FAIL sub_cond: got %b expected 0", rspCondTrue); end
    compared++; if (aluSelection !== 4'b1111) begin mismatched++; $display("[TB] FAIL sub_aluSelResp: got %b expected 1111", aluSelection); end
    finishResponse();
    compared++; if ({aluSelection, aluDataA} !== 12'hF00) begin mismatched++; $display("[TB] FAIL sub_aluIdle: got %h expected f00", {aluSelection, aluDataA}); end
  endtask

  task automatic test_backpressure();
    applyStimulus(ALU_OP_ADD, 8'hFF, 8'h01, COND_C, 1'b0);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      compared++; if ({rspValid, reqReady} !== 2'b10) begin mismatched++; $display("[TB] FAIL bp_handshake[%0d]: got %b expected 10", i, {rspValid, reqReady}); end
      compared++; if ({rspData, rspFlags, rspCondTrue} !== {8'h00, 4'b0101, 1'b1}) begin mismatched++; $display("[TB] FAIL bp_hold[%0d]: got %h/%b/%b expected 00/0101/1", i, rspData, rspFlags, rspCondTrue); end
      if (i == 1) begin
        reqOp = ALU_OP_SUB; reqDataA = 8'h33; reqDataB = 8'h11; reqCond = COND_ALWAYS;
        reqValid = 1'b1;
      end else begin
        reqValid = 1'b0;
      end
      @(posedge clock); #1;
    end
    finishResponse();
    compared++; if ({rspValid, reqReady} !== 2'b01) begin mismatched++; $display("[TB] FAIL bp_release: got %b expected 01", {rspValid, reqReady}); end
    @(posedge clock); #1;
    compared++; if ({reqReady, aluSelection} !== 5'b11111) begin mismatched++; $display("[TB] FAIL bp_ignoredReq: got %b expected 11111", {reqReady, aluSelection}); end
    compared++; if (rspData !== 8'h00) begin mismatched++; $display("[TB] FAIL bp_dataPersist: got %h expected 00", rspData); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(ALU_OP_ADD, 8'h01, 8'h01, COND_ALWAYS, 1'b0);
    @(posedge clock); #1;
    reqOp = ALU_OP_XOR; reqDataA = 8'hAA; reqDataB = 8'h55; reqCond = COND_N;
    reqValid = 1'b1;
    rspReady = 1'b1;
    @(posedge clock); #1;
    rspReady = 1'b0;
    compared++; if ({rspValid, reqReady} !== 2'b01) begin mismatched++; $display("[TB] FAIL b2b_respOnly: got %b expected 01", {rspValid, reqReady}); end
    compared++; if (aluSelection !== 4'b1111) begin mismatched++; $display("[TB] FAIL b2b_notExec: got %b expected 1111", aluSelection); end
    @(posedge clock); #1;
    reqValid = 1'b0;
    compared++; if ({reqReady, aluSelection} !== 5'b00100) begin mismatched++; $display("[TB] FAIL b2b_exec: got %b expected 00100", {reqReady, aluSelection}); end
    @(posedge clock); #1;
    compared++; if ({rspValid, rspData, rspFlags, rspCondTrue} !== {1'b1, 8'hFF, 4'b1000, 1'b1}) begin mismatched++; $display("[TB] FAIL b2b_rsp: got %b/%h/%b/%b expected 1/ff/1000/1", rspValid, rspData, rspFlags, rspCondTrue); end
    finishResponse();
  endtask

  task automatic test_reset_mid_op();
    applyStimulus(ALU_OP_ADD, 8'h7F, 8'h01, COND_N, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    compared++; if ({reqReady, rspValid, aluSelection} !== 6'b101111) begin mismatched++; $display("[TB] FAIL rst_ctrl: got %b expected 101111", {reqReady, rspValid, aluSelection}); end
    compared++; if ({aluDataA, aluDataB, rspData, rspFlags, rspCondTrue} !== 29'h0) begin mismatched++; $display("[TB] FAIL rst_data: got %h expected 0", {aluDataA, aluDataB, rspData, rspFlags, rspCondTrue}); end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      compared++; if ({rspValid, reqReady} !== 2'b01) begin mismatched++; $display("[TB] FAIL rst_noResp[%0d]: got %b expected 01", i, {rspValid, reqReady}); end
    end
    applyStimulus(ALU_OP_ADD, 8'h10, 8'h20, COND_ALWAYS, 1'b0);
    @(posedge clock); #1;
    compared++; if ({rspValid, rspData, rspFlags, rspCondTrue} !== {1'b1, 8'h30, 4'b0000, 1'b1}) begin mismatched++; $display("[TB] FAIL rst_next: got %b/%h/%b/%b expected 1/30/0000/1", rspValid, rspData, rspFlags, rspCondTrue); end
    finishResponse();
  endtask

  task automatic test_cond_and_flags();
    applyStimulus(ALU_OP_ADD, 8'hFF, 8'h01, COND_NEVER, 1'b0);
    @(posedge clock); #1;
    compared++; if ({rspFlags, rspCondTrue} !== 5'b01010) begin mismatched++; $display("[TB] FAIL never: got %b expected 01010", {rspFlags, rspCondTrue}); end
    finishResponse();
    applyStimulus(ALU_OP_AND, 8'hF0, 8'h0F, COND_C, 1'b0);
    @(posedge clock); #1;
    compared++; if ({rspData, rspFlags, rspCondTrue} !== {8'h00, 4'b0100, 1'b0}) begin mismatched++; $display("[TB] FAIL logicOverwrite: got %h/%b/%b expected 00/0100/0", rspData, rspFlags, rspCondTrue); end
    finishResponse();
    applyStimulus(ALU_OP_OR, 8'h0F, 8'hF0, COND_ALWAYS, 1'b0);
    @(posedge clock); #1;
    compared++; if ({rspData, rspFlags, rspCondTrue} !== {8'hFF, 4'b1000, 1'b1}) begin mismatched++; $display("[TB] FAIL always: got %h/%b/%b expected ff/1000/1", rspData, rspFlags, rspCondTrue); end
    finishResponse();
    applyStimulus(ALU_OP_OR, 8'h0F, 8'hF0, COND_NEVER, 1'b0);
    @(posedge clock); #1;
    compared++; if (rspCondTrue !== 1'b0) begin mismatched++; $display("[TB] FAIL neverLogic: got %b expected 0", rspCondTrue); end
    finishResponse();
  endtask

`ifdef CC_ALUSEQ_CHAIN_EN
  task automatic test_chain();
    applyStimulus(ALU_OP_INC, 8'h01, 8'h00, COND_ALWAYS, 1'b0);
    @(posedge clock); #1;
    compared++; if (rspData !== 8'h02) begin mismatched++; $display("[TB] FAIL chain_first: got %h expected 02", rspData); end
    finishResponse();
    applyStimulus(ALU_OP_INC, 8'h55, 8'h00, COND_ALWAYS, 1'b1);
    @(posedge clock); #1;
    compared++; if (rspData !== 8'h03) begin mismatched++; $display("[TB] FAIL chain_second: got %h expected 03", rspData); end
    finishResponse();
    reqChain = 1'b0;
  endtask
`endif

  // Run every scenario in order and report the totals.
  initial begin
    reset    = 1'b1;
    reqValid = 1'b0;
    reqOp    = 4'b0000;
    reqDataA = 8'h00;
    reqDataB = 8'h00;
    reqCond  = 3'b000;
    reqChain = 1'b0;
    rspReady = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_cond_and_flags();
`ifdef CC_ALUSEQ_CHAIN_EN
    test_chain();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
